// File: rtl/mdu_div_unit_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface mdu_div_unit_if #(
  parameter int XLEN = 32
);
  logic            i_req_valid;
  logic            o_req_ready;
  logic [1:0]      i_div_op;
  logic [XLEN-1:0] i_operand_a;
  logic [XLEN-1:0] i_operand_b;
  logic            i_flush;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [XLEN-1:0] o_rsp_data;
  logic            o_busy;

  modport master (
    output i_req_valid, i_div_op, i_operand_a, i_operand_b, i_flush, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_busy
  );

  modport slave (
    input  i_req_valid, i_div_op, i_operand_a, i_operand_b, i_flush, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_busy
  );
endinterface

// File: rtl/mdu_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// state | meaning:  IDLE | waiting for request,  CALC | iterating,  DONE | holding result
module mdu_div_unit #(
  parameter int XLEN = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mdu_div_unit_if.slave  bus
);
  localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic            signed_q, sign_a_q, sign_b_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, data_q;

  logic            accept, is_signed, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   rem_sh, diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_nx, quo_nx, quo_fix, rem_fix;

  always_comb begin
    accept    = bus.i_req_valid && (state_q == IDLE) && !bus.i_flush;
    is_signed = !bus.i_div_op[0];
    a_neg     = is_signed && bus.i_operand_a[XLEN-1];
    b_neg     = is_signed && bus.i_operand_b[XLEN-1];
    abs_a     = a_neg ? -bus.i_operand_a : bus.i_operand_a;
    abs_b     = b_neg ? -bus.i_operand_b : bus.i_operand_b;
    div_zero  = (bus.i_operand_b == '0);
    overflow  = is_signed && (bus.i_operand_a == MIN_NEG) && (bus.i_operand_b == ALL_ONES);
  end

  // Restoring step: the extra top bit of diff is the borrow, i.e. the inverted quotient bit.
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    q_bit   = !diff[XLEN];
    rem_nx  = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], q_bit};
    quo_fix = (signed_q && (sign_a_q != sign_b_q)) ? -quo_nx : quo_nx;
    rem_fix = (signed_q && sign_a_q) ? -rem_nx : rem_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = (div_zero || overflow) ? DONE : CALC;
        CALC:    if (cnt_q == '0) state_d = DONE;
        DONE:    if (bus.i_rsp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_req_ready = (state_q == IDLE);
    bus.o_rsp_valid = (state_q == DONE);
    bus.o_busy      = (state_q != IDLE);
    bus.o_rsp_data  = data_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      signed_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      data_q   <= '0;
    end else if (!bus.i_flush) begin
      if (accept) begin
        op_q     <= bus.i_div_op;
        signed_q <= is_signed;
        sign_a_q <= a_neg;
        sign_b_q <= b_neg;
        dvs_q    <= abs_b;
        if (div_zero) begin
          data_q <= bus.i_div_op[1] ? bus.i_operand_a : ALL_ONES;
        end else if (overflow) begin
          data_q <= bus.i_div_op[1] ? '0 : MIN_NEG;
        end else begin
          rem_q <= '0;
          quo_q <= abs_a;
          cnt_q <= CW'(XLEN-1);
        end
      end else if (state_q == CALC) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        if (cnt_q == '0) data_q <= op_q[1] ? rem_fix : quo_fix;
        else             cnt_q  <= cnt_q - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mdu_div_unit.sv
// Directed vector bench for mdu_div_unit: result values, latency, backpressure, flush and reset abort.
module tb_mdu_div_unit;
  localparam int XLEN = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic i_clk = 1'b0;
  logic i_rst;
  int   checks = 0;
  int   errors = 0;

  mdu_div_unit_if #(.XLEN(XLEN)) bus ();
  mdu_div_unit #(.XLEN(XLEN)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];
  int   nvec = 0;

  task automatic add_vec(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    vecs[nvec].name = name;
    vecs[nvec].op   = op;
    vecs[nvec].a    = a;
    vecs[nvec].b    = b;
    vecs[nvec].exp  = exp;
    vecs[nvec].lat  = lat;
    nvec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge i_clk);
    check({name, " ready"}, {31'b0, bus.o_req_ready}, 32'd1);
    bus.i_req_valid = 1'b1;
    bus.i_div_op    = op;
    bus.i_operand_a = a;
    bus.i_operand_b = b;
    @(posedge i_clk);
    #1;
    bus.i_req_valid = 1'b0;
    bus.i_operand_a = $urandom;
    bus.i_operand_b = $urandom;
  endtask

  // lat counts samples after the accept edge: the first sample is 1.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
    end while (!bus.o_rsp_valid && lat < 100);
  endtask

  task automatic take_rsp();
    bus.i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(name, op, a, b);
    wait_rsp(lat);
    check({name, " latency"}, lat, exp_lat);
    check({name, " data"}, bus.o_rsp_data, exp);
    take_rsp();
  endtask

  task automatic abort_check(input string name, input logic [31:0] exp_data);
    int seen;
    @(negedge i_clk);
    check({name, " busy"}, {31'b0, bus.o_busy}, 32'd0);
    check({name, " ready"}, {31'b0, bus.o_req_ready}, 32'd1);
    check({name, " valid"}, {31'b0, bus.o_rsp_valid}, 32'd0);
    check({name, " data"}, bus.o_rsp_data, exp_data);
    seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (bus.o_rsp_valid) seen++;
    end
    check({name, " no response"}, seen, 32'd0);
  endtask

  initial begin
    int lat;
    bus.i_req_valid = 1'b0;
    bus.i_div_op    = 2'b00;
    bus.i_operand_a = '0;
    bus.i_operand_b = '0;
    bus.i_flush     = 1'b0;
    bus.i_rsp_ready = 1'b0;
    i_rst = 1'b1;

    add_vec("divu_100_7",   OP_DIVU, 32'd100,      32'd7,          32'd14,         33);
    add_vec("remu_100_7",   OP_REMU, 32'd100,      32'd7,          32'd2,          33);
    add_vec("div_m7_2",     OP_DIV,  32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   33);
    add_vec("rem_m7_2",     OP_REM,  32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF,   33);
    add_vec("rem_7_m2",     OP_REM,  32'd7,        32'hFFFFFFFE,   32'd1,          33);
    add_vec("div_min_2",    OP_DIV,  32'h80000000, 32'd2,          32'hC0000000,   33);
    add_vec("div_m100_m7",  OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,         33);
    add_vec("rem_m100_m7",  OP_REM,  32'hFFFFFF9C, 32'hFFFFFFF9,   32'hFFFFFFFE,   33);
    add_vec("divu_max_1",   OP_DIVU, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   33);
    add_vec("remu_max_16",  OP_REMU, 32'hFFFFFFFF, 32'd16,         32'd15,         33);
    add_vec("divu_min_m1",  OP_DIVU, 32'h80000000, 32'hFFFFFFFF,   32'd0,          33);
    add_vec("divu_by0",     OP_DIVU, 32'h00001234, 32'd0,          32'hFFFFFFFF,   1);
    add_vec("rem_by0",      OP_REM,  32'h00001234, 32'd0,          32'h00001234,   1);
    add_vec("div_ovf",      OP_DIV,  32'h80000000, 32'hFFFFFFFF,   32'h80000000,   1);
    add_vec("rem_ovf",      OP_REM,  32'h80000000, 32'hFFFFFFFF,   32'd0,          1);

    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("reset ready", {31'b0, bus.o_req_ready}, 32'd1);
    check("reset valid", {31'b0, bus.o_rsp_valid}, 32'd0);
    check("reset busy",  {31'b0, bus.o_busy},      32'd0);
    check("reset data",  bus.o_rsp_data,           32'd0);

    for (int i = 0; i < nvec; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Backpressure: result must hold while new requests are offered.
    issue("bp", OP_DIVU, 32'd1000, 32'd10);
    wait_rsp(lat);
    check("bp latency", lat, 32'd33);
    bus.i_req_valid = 1'b1;
    bus.i_div_op    = OP_DIVU;
    bus.i_operand_a = 32'd77;
    bus.i_operand_b = 32'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      check("bp data",  bus.o_rsp_data, 32'd100);
      check("bp valid", {31'b0, bus.o_rsp_valid}, 32'd1);
      check("bp ready", {31'b0, bus.o_req_ready}, 32'd0);
    end
    bus.i_req_valid = 1'b0;
    take_rsp();
    @(negedge i_clk);
    check("bp release ready", {31'b0, bus.o_req_ready}, 32'd1);
    check("bp release busy",  {31'b0, bus.o_busy},      32'd0);

    // Flush at CALC iteration 10.
    issue("flush", OP_DIVU, 32'h0000FFFF, 32'd3);
    repeat (9) @(posedge i_clk);
    @(negedge i_clk);
    bus.i_flush = 1'b1;
    @(posedge i_clk);
    #1 bus.i_flush = 1'b0;
    abort_check("flush", 32'd100);
    run_op("after_flush", OP_DIVU, 32'd50, 32'd5, 32'd10, 33);

    // Flush beats a simultaneous request.
    @(negedge i_clk);
    bus.i_req_valid = 1'b1;
    bus.i_flush     = 1'b1;
    bus.i_operand_a = 32'd9;
    bus.i_operand_b = 32'd3;
    @(posedge i_clk);
    #1;
    bus.i_req_valid = 1'b0;
    bus.i_flush     = 1'b0;
    @(negedge i_clk);
    check("flush_req busy", {31'b0, bus.o_busy}, 32'd0);

    // Reset at CALC iteration 10.
    issue("rst", OP_DIV, 32'hFFFF0000, 32'd7);
    repeat (9) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    abort_check("rst", 32'd0);
    run_op("after_rst", OP_DIVU, 32'd50, 32'd5, 32'd10, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
